// File: rtl/npu_top.sv
`default_nettype none
// ============================================================================
// npu_top : memory-mapped fixed-point matrix-vector engine, y = sat((W*x)>>>SHIFT + b)
// Rev 1.0
// ============================================================================
module npu_top #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int N          = 16,
  parameter int SHIFT      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [ADDR_WIDTH-1:0] addr_in_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  result_is_OK_o,
  output logic [DATA_WIDTH-1:0] data_out_o
);

  localparam int XW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(N + 1);
  localparam int WIW = (N > 1) ? $clog2(N * N) : 1;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int AW  = PW + 8;
  localparam int SW  = AW + 1;

  localparam logic [ADDR_WIDTH-1:0] C_W_END  = ADDR_WIDTH'(N * N);
  localparam logic [ADDR_WIDTH-1:0] C_X_BASE = ADDR_WIDTH'(32'h0100);
  localparam logic [ADDR_WIDTH-1:0] C_B_BASE = ADDR_WIDTH'(32'h0110);

  localparam logic signed [SW-1:0] C_Y_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] C_Y_MIN = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DONE    = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  // Operand and result buffers are deliberately not reset.
  logic signed [DATA_WIDTH-1:0] w_mem [N*N];
  logic signed [DATA_WIDTH-1:0] x_mem [N];
  logic signed [DATA_WIDTH-1:0] b_mem [N];
  logic signed [DATA_WIDTH-1:0] y_mem [N];

  state_t                state_q, state_d;
  logic [XW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [XW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;

  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  ok_q, ok_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  wr_en, wr_w, wr_x, wr_b;
  logic                  y_we;
  logic [WIW-1:0]        w_idx;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc_sh;
  logic signed [SW-1:0]  sum;
  logic [DATA_WIDTH-1:0] y_val;

  always_comb begin
    wr_en = valid_i && (((state_q == S_IDLE) && sop_i) || (state_q == S_LOAD));
    wr_w  = wr_en && (addr_in_i < C_W_END);
    wr_x  = wr_en && (addr_in_i >= C_X_BASE) && (addr_in_i < C_X_BASE + ADDR_WIDTH'(N));
    wr_b  = wr_en && (addr_in_i >= C_B_BASE) && (addr_in_i < C_B_BASE + ADDR_WIDTH'(N));
  end

  always_comb begin
    w_idx  = WIW'(int'(row_q) * N + int'(col_q));
    prod   = w_mem[w_idx] * x_mem[col_q[XW-1:0]];
    acc_sh = acc_q >>> SHIFT;
    // Bias add and clamp happen one bit wider than the accumulator so nothing wraps.
    sum    = $signed({acc_sh[AW-1], acc_sh})
           + $signed({{(SW-DATA_WIDTH){b_mem[row_q][DATA_WIDTH-1]}}, b_mem[row_q]});
    if (sum > C_Y_MAX) begin
      y_val = C_Y_MAX[DATA_WIDTH-1:0];
    end else if (sum < C_Y_MIN) begin
      y_val = C_Y_MIN[DATA_WIDTH-1:0];
    end else begin
      y_val = sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_w) w_mem[addr_in_i[WIW-1:0]] <= data_in_i;
    if (wr_x) x_mem[addr_in_i[XW-1:0]]  <= data_in_i;
    if (wr_b) b_mem[addr_in_i[XW-1:0]]  <= data_in_i;
    if (y_we) y_mem[row_q]              <= y_val;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sop_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (eop_i) begin
          state_d = S_COMPUTE;
          row_d   = '0;
          col_d   = '0;
          acc_d   = '0;
        end
      end
      S_COMPUTE: begin
        // Column index N is the writeback slot that closes each row.
        if (col_q == CW'(N)) begin
          y_we  = 1'b1;
          col_d = '0;
          acc_d = '0;
          if (row_q == XW'(N - 1)) begin
            state_d = S_DONE;
          end else begin
            row_d = row_q + XW'(1);
          end
        end else begin
          acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
          col_d = col_q + CW'(1);
        end
      end
      S_DONE: begin
        if (ready_i) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end
      end
      S_OUT: begin
        cnt_d = cnt_q + XW'(1);
        if (cnt_q == XW'(N - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the state one edge later so every port comes straight from a flop.
  always_comb begin
    ready_d = (state_q == S_IDLE) || (state_q == S_LOAD);
    ok_d    = (state_q == S_DONE);
    valid_d = (state_q == S_OUT);
    sop_d   = (state_q == S_OUT) && (cnt_q == '0);
    eop_d   = (state_q == S_OUT) && (cnt_q == XW'(N - 1));
    data_d  = (state_q == S_OUT) ? y_mem[cnt_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ready_q <= 1'b1;
      ok_q    <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ready_q <= ready_d;
      ok_q    <= ok_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
    end
  end

  assign ready_o        = ready_q;
  assign result_is_OK_o = ok_q;
  assign valid_o        = valid_q;
  assign sop_o          = sop_q;
  assign eop_o          = eop_q;
  assign data_out_o     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_npu_top.sv
`default_nettype none
// ============================================================================
// tb_npu_top : directed self-checking bench for npu_top
// Rev 1.0
// ============================================================================
module tb_npu_top;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, sop_i, eop_i, ready_i;
  logic [15:0] data_in_i, addr_in_i;
  logic        ready_o, valid_o, sop_o, eop_o, result_is_OK_o;
  logic [15:0] data_out_o;

  always #5 clk = ~clk;

  npu_top #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .N         (N),
    .SHIFT     (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .sop_i         (sop_i),
    .eop_i         (eop_i),
    .ready_o       (ready_o),
    .data_in_i     (data_in_i),
    .addr_in_i     (addr_in_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .sop_o         (sop_o),
    .eop_o         (eop_o),
    .result_is_OK_o(result_is_OK_o),
    .data_out_o    (data_out_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q_addr [$];
  logic [15:0] q_data [$];
  logic [15:0] exp_y  [N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [15:0] a, input logic [15:0] d);
    valid_i   = v;
    sop_i     = s;
    eop_i     = e;
    addr_in_i = a;
    data_in_i = d;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
  endtask

  // sop rides on the first write, eop on the last; a one-word frame needs its own eop cycle.
  task automatic send_frame();
    int n;
    n = q_addr.size();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i == 0), (i == n - 1) && (n > 1), q_addr[i], q_data[i]);
    end
    if (n == 1) drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic push_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        push(16'(r * N + c), (r == c) ? 16'h0001 : 16'h0000);
    for (int i = 0; i < N; i++) push(16'h0100 + 16'(i), 16'(i << 8));
    for (int i = 0; i < N; i++) push(16'h0110 + 16'(i), 16'h0000);
  endtask

  task automatic wait_compute(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) check_val({tag, "_busy_ready"}, 32'(ready_o), 32'd0);
    end while (!result_is_OK_o && n < 400);
    check_val({tag, "_latency"}, n, 32'd273);
  endtask

  task automatic read_out(input string tag);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) check_val({tag, "_ok_clear"}, 32'(result_is_OK_o), 32'd0);
      check_val($sformatf("%s_valid%0d", tag, k), 32'(valid_o), 32'd1);
      check_val($sformatf("%s_y%0d", tag, k), 32'(data_out_o), 32'(exp_y[k]));
      check_val($sformatf("%s_sop%0d", tag, k), 32'(sop_o), 32'(k == 0));
      check_val($sformatf("%s_eop%0d", tag, k), 32'(eop_o), 32'(k == N - 1));
    end
    @(posedge clk);
    #1;
    check_val({tag, "_valid_end"}, 32'(valid_o), 32'd0);
    check_val({tag, "_data_end"}, 32'(data_out_o), 32'd0);
    check_val({tag, "_ready_end"}, 32'(ready_o), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"}, 32'(ready_o), 32'd1);
    check_val({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_val({tag, "_sop"}, 32'(sop_o), 32'd0);
    check_val({tag, "_eop"}, 32'(eop_o), 32'd0);
    check_val({tag, "_ok"}, 32'(result_is_OK_o), 32'd0);
    check_val({tag, "_data"}, 32'(data_out_o), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    valid_i   = 1'b0;
    sop_i     = 1'b0;
    eop_i     = 1'b0;
    ready_i   = 1'b0;
    data_in_i = '0;
    addr_in_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("post_rst");

    // Identity: W=I (raw 1), x[i]=i<<8, b=0 -> y[i]=i
    push_identity();
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'(k);
    wait_compute("ident");
    read_out("ident");

    // Partial rewrite of x[3] only
    push(16'h0103, 16'h0200);
    send_frame();
    exp_y[3] = 16'h0002;
    wait_compute("partial");
    read_out("partial");

    // Address filter: stray IDLE write, out-of-map writes inside the frame
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0005);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    push_identity();
    push(16'h0120, 16'h1234);
    push(16'hFFFF, 16'h1234);
    push(16'h011F, 16'h0000);
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'(k);
    wait_compute("filter");
    read_out("filter");

    // Bias/scale: W=x=0x0100, b[i]=i -> y[i]=0x1000+i
    for (int i = 0; i < N * N; i++) push(16'(i), 16'h0100);
    for (int i = 0; i < N; i++) push(16'h0100 + 16'(i), 16'h0100);
    for (int i = 0; i < N; i++) push(16'h0110 + 16'(i), 16'(i));
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'h1000 + 16'(k);
    wait_compute("bias");
    read_out("bias");

    // Positive saturation
    for (int i = 0; i < N * N; i++) push(16'(i), 16'h7FFF);
    for (int i = 0; i < N; i++) push(16'h0100 + 16'(i), 16'h7FFF);
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'h7FFF;
    wait_compute("satpos");
    read_out("satpos");

    // Negative saturation: rewrite x only
    for (int i = 0; i < N; i++) push(16'h0100 + 16'(i), 16'h8000);
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'h8000;
    wait_compute("satneg");
    read_out("satneg");

    // Reset 100 cycles into COMPUTE
    push_identity();
    send_frame();
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check_val("midrst_ok_stays_low", 32'(result_is_OK_o), 32'd0);
    check_val("midrst_ready_idle", 32'(ready_o), 32'd1);

    // Fresh frame after the aborted one
    push_identity();
    send_frame();
    for (int k = 0; k < N; k++) exp_y[k] = 16'(k);
    wait_compute("recover");
    read_out("recover");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
